// File: rtl/test_i5563.sv
// test_i5563 -- registered 5-input Boolean function with an optional
// rare-event trigger that inverts the output after seven matches of the
// input pattern 10110.
// Build option: define TROJAN_PAYLOAD_EN to include the trigger counter and
// payload; leave it undefined for the golden circuit (Q <= G always).
module test_i5563 (
  input  logic N0,
  input  logic N1,
  input  logic N2,
  input  logic N3,
  input  logic N4,
  input  logic CK,
  input  logic reset,
  output logic out
);

  // Golden combinational function of the five data inputs.
  logic g;
  assign g = (N0 & N1) | (N2 & ~N3) | (N4 & ~N0);

  // Payload term: inverts the output when asserted.
  logic t;

`ifdef TROJAN_PAYLOAD_EN
  // Input vector, N0 is the MSB.
  logic [4:0] n_vec;
  assign n_vec = {N0, N1, N2, N3, N4};

  // Trigger match on the rare pattern 10110.
  logic m;
  assign m = (n_vec == 5'b10110);

  // Saturating match counter; payload is active once it reaches 7.
  logic [2:0] tcnt_q;
  logic [2:0] tcnt_d;

  assign t = (tcnt_q == 3'd7);

  // Next count: step on a match unless already saturated (which keeps T sticky).
  always_comb begin
    tcnt_d = tcnt_q;
    if (m && !t) begin
      tcnt_d = tcnt_q + 3'd1;
    end
  end

  // Counter register; cleared asynchronously by reset.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      tcnt_q <= 3'd0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end
`else
  assign t = 1'b0;
`endif

  // Output next state uses the registered T, so the edge that saturates the
  // counter still produces an uninverted result.
  logic q_q;
  logic q_d;
  assign q_d = g ^ t;

  // Output register; cleared asynchronously by reset.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign out = q_q;

endmodule

// File: tb/tb_test_i5563.sv
// Directed testbench for test_i5563. Expectations follow the build option:
// with TROJAN_PAYLOAD_EN defined the output inverts after seven matches.
module tb_test_i5563;

`ifdef TROJAN_PAYLOAD_EN
  localparam bit TROJ = 1'b1;
`else
  localparam bit TROJ = 1'b0;
`endif

  // Bit i holds G for N = i (N0 is the MSB), computed by hand.
  localparam logic [31:0] GOLDEN_TBL = 32'hFF30_BABA;

  logic N0, N1, N2, N3, N4;
  logic CK;
  logic reset;
  logic out;

  int tests_run;
  int tests_failed;

  test_i5563 dut (
    .N0   (N0),
    .N1   (N1),
    .N2   (N2),
    .N3   (N3),
    .N4   (N4),
    .CK   (CK),
    .reset(reset),
    .out  (out)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Drive a vector, take one rising edge, and settle just after it.
  task automatic apply(input logic [4:0] v);
    {N0, N1, N2, N3, N4} = v;
    @(posedge CK);
    #1;
  endtask

  // Pulse reset away from the clock edge and release it on a falling edge.
  task automatic do_reset();
    @(negedge CK);
    reset = 1'b0;
    @(negedge CK);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    {N0, N1, N2, N3, N4} = 5'b11000;
    #2;
    tests_run++;
    if (out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async out=%b expected=0", out);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge CK);
      #1;
      tests_run++;
      if (out !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_hold edge=%0d out=%b expected=0", i, out);
      end
    end
    @(negedge CK);
    reset = 1'b1;
    apply(5'b11000);
    tests_run++;
    if (out !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release out=%b expected=1", out);
    end
    $display("[TB] reset: held 3 edges, released, out=%b", out);
  endtask

  task automatic test_golden_sweep();
    logic [31:0] tbl;
    logic [4:0]  v;
    tbl = GOLDEN_TBL;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      if (i != 22) begin
        v = 5'(i);
        apply(v);
        tests_run++;
        if (out !== tbl[i]) begin
          tests_failed++;
          $display("FAIL golden N=%b out=%b expected=%b", v, out, tbl[i]);
        end else begin
          $display("[TB] golden N=%b out=%b", v, out);
        end
      end
    end
  endtask

  task automatic test_trigger();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      apply(5'b10110);
      tests_run++;
      if (out !== 1'b0) begin
        tests_failed++;
        $display("FAIL trigger_match%0d out=%b expected=0", i, out);
      end
    end
    apply(5'b00000);
    tests_run++;
    if (out !== TROJ) begin
      tests_failed++;
      $display("FAIL trigger_00000 out=%b expected=%b", out, TROJ);
    end
    apply(5'b11000);
    tests_run++;
    if (out !== ~TROJ) begin
      tests_failed++;
      $display("FAIL trigger_11000 out=%b expected=%b", out, ~TROJ);
    end
    apply(5'b00001);
    tests_run++;
    if (out !== ~TROJ) begin
      tests_failed++;
      $display("FAIL trigger_00001 out=%b expected=%b", out, ~TROJ);
    end
    $display("[TB] trigger: 7 matches then 00000/11000/00001, last out=%b", out);
  endtask

  task automatic test_nonconsecutive();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      apply(5'b00000);
      tests_run++;
      if (out !== 1'b0) begin
        tests_failed++;
        $display("FAIL nonconsec_gap%0d out=%b expected=0", i, out);
      end
      apply(5'b10110);
      tests_run++;
      if (out !== 1'b0) begin
        tests_failed++;
        $display("FAIL nonconsec_match%0d out=%b expected=0", i, out);
      end
    end
    apply(5'b00000);
    tests_run++;
    if (out !== TROJ) begin
      tests_failed++;
      $display("FAIL nonconsec_after out=%b expected=%b", out, TROJ);
    end
    // Further matches at saturation keep the payload active.
    apply(5'b10110);
    tests_run++;
    if (out !== TROJ) begin
      tests_failed++;
      $display("FAIL saturate_match out=%b expected=%b", out, TROJ);
    end
    apply(5'b11111);
    tests_run++;
    if (out !== ~TROJ) begin
      tests_failed++;
      $display("FAIL saturate_11111 out=%b expected=%b", out, ~TROJ);
    end
    $display("[TB] nonconsecutive: 7 spaced matches, saturation, last out=%b", out);
  endtask

  task automatic test_reset_mid_payload();
    // Payload is active here in the trojan build (continues from prior test).
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (out !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_async out=%b expected=0", out);
    end
    @(negedge CK);
    reset = 1'b1;
    apply(5'b00001);
    tests_run++;
    if (out !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_00001 out=%b expected=1", out);
    end
    apply(5'b10110);
    tests_run++;
    if (out !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_match out=%b expected=0", out);
    end
    apply(5'b00000);
    tests_run++;
    if (out !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_cleared out=%b expected=0", out);
    end
    $display("[TB] reset mid-payload: golden restored, out=%b", out);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    {N0, N1, N2, N3, N4} = 5'b00000;
    reset = 1'b0;
    test_reset();
    test_golden_sweep();
    test_trigger();
    test_nonconsecutive();
    test_reset_mid_payload();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/test_i5563.md
# test_i5563

Small sequential benchmark circuit for the hardware-trojan detection flow. It registers a fixed 5-input Boolean function into a single output bit. It also contains an optional rare-event trigger (a "trojan") that inverts the output once a specific input pattern has been seen seven times. Simulation sweeps of this block produce the golden versus infected response tables consumed by the detection tooling.

## Interface
- No parameters.
- CK — input, 1 — clock; all state updates on rising edge.
- reset — input, 1 — asynchronous, active-low reset (0 = reset asserted).
- N0 — input, 1 — data input 0 (MSB of the 5-bit vector N = {N0,N1,N2,N3,N4}).
- N1 — input, 1 — data input 1.
- N2 — input, 1 — data input 2.
- N3 — input, 1 — data input 3.
- N4 — input, 1 — data input 4 (LSB).
- out — output, 1 — registered result Q.
- Port order: N0, N1, N2, N3, N4, CK, reset, out.

## Operation
- Golden function, combinational: G = (N0 & N1) | (N2 & ~N3) | (N4 & ~N0).
- Trigger match: M = 1 when {N0..N4} == 5'b10110; otherwise M = 0.
- Trigger counter tcnt, 3 bits:
  - Increments on each rising edge where M = 1.
  - Saturates at 7; never wraps.
  - Matches need not be consecutive.
- Payload: T = (tcnt == 7), using the current registered value of tcnt.
  - Once T = 1 it stays 1 until reset (sticky).
- Output register: Q <= G ^ T on every rising edge; out = Q.
- No handshake. The inputs are sampled every cycle and have no valid qualifier.
- Implementation style: flat gate/assign-level logic plus the two registers (Q, tcnt). No memories and no latches.

## Timing
- Reset asserted (reset = 0), immediately and asynchronously: Q = 0, tcnt = 0, so out = 0.
- Reset deassertion is synchronized by the first rising edge; no extra cycles are required.
- Latency: out reflects the N value sampled at rising edge k, and is valid after edge k until edge k+1.
- Counter and output update in the same edge:
  - The edge that brings tcnt to 7 still uses T = 0 for Q.
  - Inversion first appears on the following edge.
- Saturation: further matches at tcnt = 7 leave tcnt at 7.
- Reset mid-operation, including while T = 1: both registers clear at once, and T = 0 thereafter until seven new matches occur.
- Inputs must be stable around the rising edge. Changes between edges have no effect.

## Configuration
- Macro: TROJAN_PAYLOAD_EN.
- Defined: tcnt and payload T are built as described, and Q <= G ^ T.
- Undefined:
  - tcnt is not instantiated and T is tied to 0, so Q <= G always (golden circuit).
  - Port list and reset behaviour are unchanged.

## Test plan
- Reset: hold reset = 0 with N = 11000 across several edges -> out = 0; release reset, next edge -> out = 1.
- Golden sweep (fresh reset, TROJAN_PAYLOAD_EN defined, no 10110 applied): apply all 32 values, one per edge. Out after each edge equals G, for example:
  - 00000 -> 0
  - 00001 -> 1
  - 00100 -> 1
  - 00110 -> 0
  - 10001 -> 0
  - 11000 -> 1
  - 11111 -> 1
- Trigger:
  - Apply 10110 for 7 edges -> out = 0 each time.
  - Then 00000 -> out = 1.
  - Then 11000 -> out = 0.
  - Then 00001 -> out = 0 (all inverted).
- Non-consecutive matches: alternate 10110 and 00000 for 14 edges -> no inversion during them. The next edge with 00000 -> out = 1.
- Reset mid-payload: after the trigger fires, pulse reset = 0 -> out = 0 asynchronously. Then 00001 -> out = 1 (golden restored).
- Macro undefined: repeat the trigger scenario -> out matches G throughout. After 7× 10110, then 00000 -> out = 0.
